// File: rtl/bmc_soft_pipe.sv
// Branch-metric computer for a soft/hard-decision Viterbi decoder.
// Two-stage valid/ready pipeline: raw metrics, then minimum and optional normalisation.
module bmc_soft_pipe #(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 3,
  localparam int MET_W = SOFT_W + $clog2(N_OUT),
  localparam int N_HYP = 1 << N_OUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_OUT*SOFT_W-1:0]  rx_soft,
  input  logic [N_OUT-1:0]         erase,
  input  logic                     hard_mode,
  input  logic                     norm_en,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_HYP*MET_W-1:0]   bm,
  output logic [MET_W-1:0]         bm_min
);

  localparam logic [SOFT_W-1:0] SMAX = '1;

  logic             s1_v;
  logic             s2_v;
  logic             s1_free;
  logic             s2_free;
  logic             accept;
  logic             s2_load;
  logic             norm_q;
  logic [MET_W-1:0] raw_d [N_HYP];
  logic [MET_W-1:0] raw_q [N_HYP];
  logic [MET_W-1:0] bm_d  [N_HYP];
  logic [MET_W-1:0] mn;

  // A stage may load when it is empty or its content leaves on the same edge.
  assign s2_free   = !s2_v || out_ready;
  assign s1_free   = !s1_v || s2_free;
  assign in_ready  = s1_free;
  assign accept    = in_valid && s1_free && !flush;
  assign s2_load   = s1_v && s2_free && !flush;
  assign out_valid = s2_v;

  always_comb begin : raw_calc
    logic [SOFT_W-1:0] r;
    logic [N_OUT-1:0]  hyp;
    logic [MET_W-1:0]  d;
    r   = '0;
    hyp = '0;
    d   = '0;
    for (int h = 0; h < N_HYP; h++) begin
      raw_d[h] = '0;
      hyp      = N_OUT'(h);
      for (int i = 0; i < N_OUT; i++) begin
        r = rx_soft[i*SOFT_W +: SOFT_W];
        if (erase[i])
          d = '0;
        else if (hard_mode)
          d = MET_W'(r[SOFT_W-1] ^ hyp[i]);
        else if (hyp[i])
          d = MET_W'(SMAX - r);
        else
          d = MET_W'(r);
        raw_d[h] = raw_d[h] + d;
      end
    end
  end

  always_comb begin : min_norm
    mn = raw_q[0];
    for (int h = 1; h < N_HYP; h++) begin
      if (raw_q[h] < mn)
        mn = raw_q[h];
    end
    for (int h = 0; h < N_HYP; h++) begin
      bm_d[h] = norm_q ? (raw_q[h] - mn) : raw_q[h];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (s1_free)
        s1_v <= in_valid;
      if (s2_free)
        s2_v <= s1_v;
    end
  end

  // norm_en travels with the symbol; hard_mode and erase are already folded into raw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_q <= 1'b0;
      for (int h = 0; h < N_HYP; h++)
        raw_q[h] <= '0;
    end else if (accept) begin
      norm_q <= norm_en;
      for (int h = 0; h < N_HYP; h++)
        raw_q[h] <= raw_d[h];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bm     <= '0;
      bm_min <= '0;
    end else if (s2_load) begin
      bm_min <= mn;
      for (int h = 0; h < N_HYP; h++)
        bm[h*MET_W +: MET_W] <= bm_d[h];
    end
  end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Self-checking bench for bmc_soft_pipe (N_OUT=2, SOFT_W=3): directed vectors,
// back-pressure, randomized stream with flush, and reset behaviour.
module tb_bmc_soft_pipe;

  typedef struct packed {
    logic [15:0] bm;
    logic [3:0]  mn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  rx_soft = '0;
  logic [1:0]  erase = '0;
  logic        hard_mode = 1'b0;
  logic        norm_en = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] bm;
  logic [3:0]  bm_min;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];

  bmc_soft_pipe #(.N_OUT(2), .SOFT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rx_soft   (rx_soft),
    .erase     (erase),
    .hard_mode (hard_mode),
    .norm_en   (norm_en),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bm        (bm),
    .bm_min    (bm_min)
  );

  always #5 clk = ~clk;

  // Reference: distance per bit from the received value, summed per hypothesis.
  function automatic exp_t model(input logic [5:0] rx, input logic [1:0] er,
                                 input logic hard, input logic norm);
    int   raw [4];
    int   r;
    int   hb;
    int   m;
    exp_t e;
    for (int h = 0; h < 4; h++) begin
      raw[h] = 0;
      for (int i = 0; i < 2; i++) begin
        r  = int'(rx[i*3 +: 3]);
        hb = (h >> i) & 1;
        if (er[i] == 1'b0)
          raw[h] += hard ? ((r >> 2) ^ hb) : (hb == 1 ? 7 - r : r);
      end
    end
    m = raw[0];
    for (int h = 1; h < 4; h++)
      if (raw[h] < m) m = raw[h];
    e.mn = 4'(m);
    e.bm = '0;
    for (int h = 0; h < 4; h++)
      e.bm[h*4 +: 4] = 4'(norm ? raw[h] - m : raw[h]);
    return e;
  endfunction

  task automatic idle_inputs();
    in_valid  = 1'b0;
    rx_soft   = '0;
    erase     = '0;
    hard_mode = 1'b0;
    norm_en   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || bm !== 16'h0 || bm_min !== 4'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got out_valid=%b bm=%h bm_min=%h, want 0 0000 0", out_valid, bm, bm_min);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  // Starts and ends just after a rising edge, with an empty pipeline.
  task automatic send_one(input string name, input logic [5:0] rx, input logic [1:0] er,
                          input logic hard, input logic norm,
                          input logic [15:0] want_bm, input logic [3:0] want_min);
    in_valid  = 1'b1;
    rx_soft   = rx;
    erase     = er;
    hard_mode = hard;
    norm_en   = norm;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    rx_soft   = ~rx;
    erase     = ~er;
    hard_mode = ~hard;
    norm_en   = ~norm;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_latency_early: out_valid=%b after 1 edge, want 0", name, out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || bm !== want_bm || bm_min !== want_min) begin
      n_err++;
      $display("FAIL %s_result: got out_valid=%b bm=%h bm_min=%0d, want 1 %h %0d",
               name, out_valid, bm, bm_min, want_bm, want_min);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_no_dup: out_valid=%b after transfer, want 0", name, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    exp_t       e;
    logic [5:0] rx;
    logic [1:0] er;
    logic       h;
    logic       n;
    send_one("soft_7_0",  {3'd0, 3'd7}, 2'b00, 1'b0, 1'b0, {4'd7, 4'd14, 4'd0, 4'd7}, 4'd0);
    send_one("soft_norm", {3'd4, 3'd3}, 2'b00, 1'b0, 1'b1, {4'd1, 4'd0, 4'd2, 4'd1}, 4'd6);
    send_one("hard",      {3'd4, 3'd3}, 2'b00, 1'b1, 1'b0, {4'd1, 4'd0, 4'd2, 4'd1}, 4'd0);
    send_one("erase_b1",  {3'd5, 3'd7}, 2'b10, 1'b0, 1'b0, {4'd0, 4'd7, 4'd0, 4'd7}, 4'd0);
    send_one("erase_all", {3'd6, 3'd1}, 2'b11, 1'b0, 1'b1, 16'h0000, 4'd0);
    for (int k = 0; k < 6; k++) begin
      rx = 6'($urandom);
      er = 2'($urandom);
      h  = 1'($urandom);
      n  = 1'($urandom);
      e  = model(rx, er, h, n);
      send_one("rand_vec", rx, er, h, n, e.bm, e.mn);
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          got = 0;
    logic        stall_prev = 1'b0;
    logic        exp_rdy;
    logic [15:0] bm_prev = '0;
    logic [3:0]  min_prev = '0;
    q.delete();
    for (int c = 0; c < 80 && got < 8; c++) begin
      in_valid  = (sent < 8);
      rx_soft   = 6'($urandom);
      erase     = 2'b00;
      hard_mode = 1'($urandom);
      norm_en   = 1'($urandom);
      out_ready = (c % 3 == 0);
      @(negedge clk);
      if (stall_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || bm !== bm_prev || bm_min !== min_prev) begin
          n_err++;
          $display("FAIL b2b_hold: got out_valid=%b bm=%h bm_min=%0d, want 1 %h %0d",
                   out_valid, bm, bm_min, bm_prev, min_prev);
        end
      end
      exp_rdy = !(q.size() == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL b2b_in_ready: got %b want %b (in flight %0d)", in_ready, exp_rdy, q.size());
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: got out_valid=1 want no pending symbol");
        end else begin
          if (bm !== q[0].bm || bm_min !== q[0].mn) begin
            n_err++;
            $display("FAIL b2b_data: got bm=%h bm_min=%0d want %h %0d", bm, bm_min, q[0].bm, q[0].mn);
          end
          void'(q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back(model(rx_soft, erase, hard_mode, norm_en));
        sent++;
      end
      stall_prev = (out_valid === 1'b1) && !out_ready;
      bm_prev    = bm;
      min_prev   = bm_min;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (got != 8 || q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_count: got %0d delivered %0d pending, want 8 delivered 0 pending", got, q.size());
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic        stall_prev = 1'b0;
    logic        exp_rdy;
    logic [15:0] bm_prev = '0;
    logic [3:0]  min_prev = '0;
    int          c = 0;
    q.delete();
    while (c < 460 && (c < 400 || q.size() != 0)) begin
      if (c < 400) begin
        in_valid  = ($urandom_range(3) != 0);
        rx_soft   = 6'($urandom);
        erase     = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
        hard_mode = 1'($urandom);
        norm_en   = 1'($urandom);
        out_ready = 1'($urandom);
        flush     = ($urandom_range(31) == 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
      end
      @(negedge clk);
      if (stall_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || bm !== bm_prev || bm_min !== min_prev) begin
          n_err++;
          $display("FAIL rnd_hold: got out_valid=%b bm=%h bm_min=%0d, want 1 %h %0d",
                   out_valid, bm, bm_min, bm_prev, min_prev);
        end
      end
      exp_rdy = !(q.size() == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rnd_in_ready: got %b want %b (in flight %0d)", in_ready, exp_rdy, q.size());
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_spurious: got out_valid=1 want no pending symbol");
        end else if (bm !== q[0].bm || bm_min !== q[0].mn) begin
          n_err++;
          $display("FAIL rnd_data: got bm=%h bm_min=%0d want %h %0d", bm, bm_min, q[0].bm, q[0].mn);
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (out_valid === 1'b1 && out_ready && q.size() != 0)
          void'(q.pop_front());
        if (in_valid && in_ready === 1'b1)
          q.push_back(model(rx_soft, erase, hard_mode, norm_en));
      end
      stall_prev = (out_valid === 1'b1) && !out_ready && !flush;
      bm_prev    = bm;
      min_prev   = bm_min;
      @(posedge clk); #1;
      c++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rnd_drain: got %0d symbols pending, want 0", q.size());
    end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    exp_t e;
    logic seen = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rx_soft   = {3'd0, 3'd7};
    @(posedge clk); #1;
    rx_soft   = {3'd2, 3'd5};
    @(posedge clk); #1;
    in_valid  = 1'b1;
    rx_soft   = {3'd7, 3'd7};
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || bm !== {4'd7, 4'd14, 4'd0, 4'd7}) begin
      n_err++;
      $display("FAIL flush_pre: got out_valid=%b bm=%h want 1 7e07", out_valid, bm);
    end
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clear: got out_valid=%b want 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      seen = seen | out_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ghost: got out_valid=%b after flush want 0", seen);
    end
    @(posedge clk); #1;
    e = model({3'd1, 3'd6}, 2'b00, 1'b0, 1'b1);
    send_one("post_flush", {3'd1, 3'd6}, 2'b00, 1'b0, 1'b1, e.bm, e.mn);
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rx_soft   = {3'd0, 3'd7};
    @(posedge clk); #1;
    rx_soft   = {3'd3, 3'd1};
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || bm !== {4'd7, 4'd14, 4'd0, 4'd7} || bm_min !== 4'd0) begin
      n_err++;
      $display("FAIL rstmid_pre: got out_valid=%b bm=%h bm_min=%0d want 1 7e07 0", out_valid, bm, bm_min);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || bm !== 16'h0 || bm_min !== 4'h0) begin
      n_err++;
      $display("FAIL rstmid_clear: got out_valid=%b bm=%h bm_min=%0d want 0 0000 0", out_valid, bm, bm_min);
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_in_ready: got %b want 1", in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | out_valid;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_ghost: got out_valid=%b after reset want 0", seen);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end

endmodule
